// File: rtl/multicycle_control_unit_if.sv
// Handshake bundle between the multicycle control unit (master) and the datapath/memory (slave).
interface multicycle_control_unit_if #(parameter int ACW = 3);
  logic [5:0]     Opcode;
  logic [5:0]     Funct;
  logic           Zero;
  logic           MemReady;
  logic           IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     PCSrc;
  logic           PCEn;
  logic [ACW-1:0] ALUControl;
  logic           IllegalOp;
  logic [3:0]     State;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State
  );
  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: Moore controls per state, write strobes
// gated by MemReady/Zero and masked combinationally while rst is high.
module multicycle_control_unit #(
  parameter int ACW     = 3,
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J  = 6'b000010, OP_BEQ = 6'b000100,
                         OP_BNE   = 6'b000101, OP_ADDI = 6'b001000,
                         OP_LW    = 6'b100011, OP_SW = 6'b101011;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_e     state_q, state_d;
  logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctl, funct_alu;

  // Unknown Funct values quietly default to add
  always_comb begin
    case (bus.Funct)
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    illegal  = 1'b0;
    aluctl   = ALU_AND;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluctl  = ALU_ADD;
        irwrite = bus.MemReady;
        pcen    = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluctl  = ALU_ADD;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_BNE: begin
            state_d = EN_BNE ? S_BRANCH : S_FETCH;
            illegal = !EN_BNE;
          end
          OP_ADDI: begin
            state_d = EN_ADDI ? S_ADDIEX : S_FETCH;
            illegal = !EN_ADDI;
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctl  = ALU_ADD;
        if (bus.Opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.Opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluctl  = funct_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluctl  = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = (bus.Opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctl  = ALU_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Architectural side effects are suppressed for the whole reset cycle
  assign bus.IRWrite    = irwrite  & ~rst;
  assign bus.PCEn       = pcen     & ~rst;
  assign bus.RegWrite   = regwrite & ~rst;
  assign bus.MemWrite   = memwrite & ~rst;
  assign bus.IllegalOp  = illegal  & ~rst;
  assign bus.IorD       = iord;
  assign bus.RegDst     = regdst;
  assign bus.MemtoReg   = memtoreg;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.PCSrc      = pcsrc;
  assign bus.ALUControl = ACW'(aluctl);
  assign bus.State      = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Two configurations run side by side on one stimulus stream; each is checked
// against an instruction-level expansion of expected per-cycle controls.
module tb_multicycle_control_unit;
  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       zero, memready;
  int         nchk = 0, npass = 0, nfail = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_BNE = 4, C_ADDI = 5, C_J = 6, C_ILL = 7;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

  multicycle_control_unit_if #(.ACW(3)) ia ();
  multicycle_control_unit_if #(.ACW(4)) ib ();

  assign ia.Opcode = opcode;  assign ib.Opcode = opcode;
  assign ia.Funct = funct;    assign ib.Funct = funct;
  assign ia.Zero = zero;      assign ib.Zero = zero;
  assign ia.MemReady = memready; assign ib.MemReady = memready;

  multicycle_control_unit ua (.clk(clk), .rst(rst), .bus(ia));
  multicycle_control_unit #(.ACW(4), .EN_BNE(1'b0), .EN_ADDI(1'b0)) ub (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] oa, ob;
  assign oa = {ia.State, ia.IorD, ia.IRWrite, ia.MemWrite, ia.RegDst, ia.MemtoReg, ia.RegWrite,
               ia.ALUSrcA, ia.ALUSrcB, ia.PCSrc, ia.PCEn, ia.IllegalOp, 1'b0, ia.ALUControl};
  assign ob = {ib.State, ib.IorD, ib.IRWrite, ib.MemWrite, ib.RegDst, ib.MemtoReg, ib.RegWrite,
               ib.ALUSrcA, ib.ALUSrcB, ib.PCSrc, ib.PCEn, ib.IllegalOp, ib.ALUControl};

  function automatic logic [20:0] mk(input logic [3:0] st, input logic iord, irw, mwr, rdst, m2r, rw,
                                     srca, input logic [1:0] srcb, pcs, input logic pcen, ill,
                                     input logic [3:0] alu);
    return {st, iord, irw, mwr, rdst, m2r, rw, srca, srcb, pcs, pcen, ill, alu};
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return SUB;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return ADD;
    endcase
  endfunction

  // Expected controls for each step of an instruction's life
  function automatic logic [20:0] r_fetch(input logic mr);   return mk(4'd0, 0, mr, 0, 0, 0, 0, 0, 2'b01, 2'b00, mr, 0, ADD); endfunction
  function automatic logic [20:0] r_decode(input logic ill); return mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, ill, ADD); endfunction
  function automatic logic [20:0] r_memadr();               return mk(4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, ADD); endfunction
  function automatic logic [20:0] r_memrd();                return mk(4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4'd0); endfunction
  function automatic logic [20:0] r_memwb();                return mk(4'd4, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 4'd0); endfunction
  function automatic logic [20:0] r_memwr();                return mk(4'd5, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4'd0); endfunction
  function automatic logic [20:0] r_exec(input logic [5:0] f); return mk(4'd6, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, alu_of(f)); endfunction
  function automatic logic [20:0] r_aluwb();                return mk(4'd7, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 4'd0); endfunction
  function automatic logic [20:0] r_branch(input logic pe); return mk(4'd8, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, pe, 0, SUB); endfunction
  function automatic logic [20:0] r_addiex();               return mk(4'd9, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, ADD); endfunction
  function automatic logic [20:0] r_addiwb();               return mk(4'd10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 4'd0); endfunction
  function automatic logic [20:0] r_jump();                 return mk(4'd11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 4'd0); endfunction

  logic [20:0] qa[$], qb[$];
  logic        mrq[$];

  task automatic pa(input logic [20:0] r, input logic mr);
    qa.push_back(r);
    mrq.push_back(mr);
  endtask

  task automatic build(input int cls, input logic [5:0] fn, input logic z, input int fw, input int mw);
    qa.delete(); qb.delete(); mrq.delete();
    for (int i = 0; i < fw; i++) pa(r_fetch(1'b0), 1'b0);
    pa(r_fetch(1'b1), 1'b1);
    pa(r_decode(cls == C_ILL), 1'b0);
    case (cls)
      C_LW: begin
        pa(r_memadr(), 1'b0);
        for (int i = 0; i < mw; i++) pa(r_memrd(), 1'b0);
        pa(r_memrd(), 1'b1);
        pa(r_memwb(), 1'b0);
      end
      C_SW: begin
        pa(r_memadr(), 1'b0);
        for (int i = 0; i < mw; i++) pa(r_memwr(), 1'b0);
        pa(r_memwr(), 1'b1);
      end
      C_R:    begin pa(r_exec(fn), 1'b0); pa(r_aluwb(), 1'b0); end
      C_BEQ:  pa(r_branch(z), 1'b0);
      C_BNE:  pa(r_branch(~z), 1'b0);
      C_ADDI: begin pa(r_addiex(), 1'b0); pa(r_addiwb(), 1'b0); end
      C_J:    pa(r_jump(), 1'b0);
      default: ;
    endcase
    pa(r_fetch(1'b0), 1'b0);
    // Second configuration rejects bne/addi in DECODE and returns straight to FETCH
    if (cls == C_BNE || cls == C_ADDI) begin
      for (int i = 0; i <= fw; i++) qb.push_back(qa[i]);
      qb.push_back(r_decode(1'b1));
      qb.push_back(r_fetch(1'b0));
    end else begin
      qb = qa;
    end
  endtask

  task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
    nchk++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [5:0] op_of(input int cls);
    logic [5:0] bad [3];
    bad = '{6'b111111, 6'b001100, 6'b100001};
    case (cls)
      C_LW:   return 6'b100011;
      C_SW:   return 6'b101011;
      C_R:    return 6'b000000;
      C_BEQ:  return 6'b000100;
      C_BNE:  return 6'b000101;
      C_ADDI: return 6'b001000;
      C_J:    return 6'b000010;
      default: return bad[$urandom_range(2, 0)];
    endcase
  endfunction

  // Reset with MemReady high (gating visible in FETCH), then play out the instruction
  task automatic run_instr(input int cls, input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    build(cls, fn, z, fw, mw);
    rst = 1'b1; memready = 1'b1; opcode = op; funct = fn; zero = z;
    @(negedge clk);
    chk($sformatf("A rst_gate op=%b", op), oa, r_fetch(1'b0));
    chk($sformatf("B rst_gate op=%b", op), ob, r_fetch(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < mrq.size(); k++) begin
      memready = mrq[k];
      @(negedge clk);
      chk($sformatf("A op=%b fn=%b z=%0d k=%0d", op, fn, z, k), oa, qa[k]);
      if (k < qb.size()) chk($sformatf("B op=%b fn=%b z=%0d k=%0d", op, fn, z, k), ob, qb[k]);
      @(posedge clk); #1;
    end
  endtask

  task automatic step_chk(input string tag, input logic [20:0] e);
    @(negedge clk);
    chk({"A ", tag}, oa, e);
    chk({"B ", tag}, ob, e);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] fl [6];
    int cls;
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    rst = 1'b1; memready = 1'b0; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step_chk("reset_state", r_fetch(1'b0));

    // Directed: latency, stalls, branches, illegal opcode, Funct sweep
    run_instr(C_LW,  op_of(C_LW),  6'b100000, 1'b0, 0, 0);
    run_instr(C_SW,  op_of(C_SW),  6'b100000, 1'b0, 0, 3);
    run_instr(C_BEQ, op_of(C_BEQ), 6'b100000, 1'b1, 0, 0);
    run_instr(C_BNE, op_of(C_BNE), 6'b100000, 1'b1, 0, 0);
    run_instr(C_BNE, op_of(C_BNE), 6'b100000, 1'b0, 1, 0);
    run_instr(C_ADDI, op_of(C_ADDI), 6'b100000, 1'b0, 0, 0);
    run_instr(C_J,   op_of(C_J),   6'b100000, 1'b0, 2, 0);
    run_instr(C_ILL, 6'b111111,    6'b100000, 1'b0, 0, 0);
    foreach (fl[i]) run_instr(C_R, 6'b000000, fl[i], 1'b0, 0, 0);

    // Reset while waiting in MEMRD
    rst = 1'b1; memready = 1'b0; opcode = op_of(C_LW);
    @(posedge clk); #1;
    rst = 1'b0; memready = 1'b1;
    step_chk("r40 fetch", r_fetch(1'b1));
    memready = 1'b0;
    step_chk("r40 decode", r_decode(1'b0));
    step_chk("r40 memadr", r_memadr());
    step_chk("r40 memrd", r_memrd());
    rst = 1'b1;
    step_chk("r40 memrd_rst", r_memrd());
    rst = 1'b0;
    step_chk("r40 after_rst", r_fetch(1'b0));

    // Randomized instruction mix
    for (int n = 0; n < 30; n++) begin
      logic [5:0] fn;
      cls = $urandom_range(7, 0);
      fn  = ($urandom_range(3, 0) == 0) ? 6'($urandom) : fl[$urandom_range(5, 0)];
      run_instr(cls, op_of(cls), fn, 1'($urandom), $urandom_range(2, 0), $urandom_range(3, 0));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
